// File: rtl/mem_copier.sv
// Word-granular memory-to-memory copier with range checking and overlap-safe ordering.
// One word moves per RD/WR pair; all outputs are registered.
module mem_copier #(
  parameter logic [15:0] LOW_ADDR  = 16'h0008,
  parameter logic [15:0] HIGH_ADDR = 16'h7FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state, state_nx;
  logic [15:0] src_q, dst_q, len_q;
  logic [15:0] off, off_nx;
  logic        back_q;
  logic [15:0] buffer, buf_nx;
  logic        busy_nx, done_nx, err_nx, rd_nx, wr_nx;
  logic [15:0] addr_nx;

  logic [16:0] src_end, dst_end;
  logic        req_bad, req_back, last;

  // 17-bit end addresses so a wrap past 16'hFFFF shows up as out of range
  always_comb begin
    src_end  = {1'b0, src} + {1'b0, len} - 17'd1;
    dst_end  = {1'b0, dst} + {1'b0, len} - 17'd1;
    req_bad  = (src < LOW_ADDR) || (dst < LOW_ADDR) ||
               (src_end > {1'b0, HIGH_ADDR}) || (dst_end > {1'b0, HIGH_ADDR});
    req_back = (dst > src) && ({1'b0, dst} <= src_end);
    last     = back_q ? (off == '0) : (off == len_q - 16'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      buffer    <= '0;
      off       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      back_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      mem_read  <= rd_nx;
      mem_write <= wr_nx;
      mem_addr  <= addr_nx;
      buffer    <= buf_nx;
      off       <= off_nx;
      if (state == IDLE && start) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        back_q <= req_back;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (req_bad || len == '0) ? FIN : RD;
      RD:      state_nx = WR;
      WR:      state_nx = last ? FIN : RD;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; the first RD address is formed from
  // the live request inputs because the latched copies are not yet valid.
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    rd_nx   = 1'b0;
    wr_nx   = 1'b0;
    addr_nx = mem_addr;
    buf_nx  = buffer;
    off_nx  = off;
    unique case (state)
      IDLE: begin
        if (start) begin
          off_nx = req_back ? len - 16'd1 : '0;
          if (state_nx == FIN) begin
            done_nx = 1'b1;
            err_nx  = req_bad;
          end else begin
            rd_nx   = 1'b1;
            busy_nx = 1'b1;
            addr_nx = src + off_nx;
          end
        end
      end
      RD: begin
        wr_nx   = 1'b1;
        busy_nx = 1'b1;
        addr_nx = dst_q + off;
        buf_nx  = mem_rdata;
      end
      WR: begin
        if (last) begin
          done_nx = 1'b1;
        end else begin
          off_nx  = back_q ? off - 16'd1 : off + 16'd1;
          rd_nx   = 1'b1;
          busy_nx = 1'b1;
          addr_nx = src_q + off_nx;
        end
      end
      FIN:     ;
      default: ;
    endcase
  end

  assign mem_wdata = buffer;

endmodule

// File: tb/tb_mem_copier.sv
// Scoreboard bench for mem_copier: a memmove-style reference model predicts every
// memory access and completion; a negedge monitor checks what the copier presents.
module tb_mem_copier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done, err, mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_copier #(.LOW_ADDR(16'h0008), .HIGH_ADDR(16'h7FFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  assign mem_rdata = mem_read ? mem[mem_addr] : 16'h0000;

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } acc_t;
  typedef struct { bit err; int cyc; int busy; } done_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } poke_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  poke_t poke_q[$];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0, ndone = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Reference model: reject by range, else memmove semantics with the ordering
  // (forward / backward) decided purely by the overlap rule.
  task automatic push_expect(input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] l, input int k);
    int si, di, li, idx;
    bit bad, back;
    done_t r;
    acc_t a;
    si = int'(s); di = int'(d); li = int'(l);
    bad  = si < 8 || di < 8 || si + li - 1 > 'h7FFF || di + li - 1 > 'h7FFF;
    back = !bad && di > si && di <= si + li - 1;
    r.err  = bad;
    r.cyc  = (bad || li == 0) ? k : k + 2 * li;
    r.busy = (bad || li == 0) ? 0 : 2 * li;
    done_q.push_back(r);
    if (!bad) begin
      for (int j = 0; j < li; j++) begin
        idx    = back ? li - 1 - j : j;
        a.wr   = 1'b0; a.addr = 16'(si + idx); a.data = '0;
        acc_q.push_back(a);
        a.wr   = 1'b1; a.addr = 16'(di + idx); a.data = ref_mem[16'(si + idx)];
        acc_q.push_back(a);
      end
    end
  endtask

  // Monitor, memory model and pokes share one process so the arrays have a single writer.
  bit filled = 1'b0, prev_done = 1'b0;
  int busy_cnt = 0;
  always @(negedge clk) begin : mon
    acc_t  a;
    done_t r;
    poke_t p;
    if (!filled) begin
      for (int i = 0; i < 65536; i++) begin
        mem[i]     = 16'($urandom);
        ref_mem[i] = mem[i];
      end
      filled = 1'b1;
    end
    while (poke_q.size() > 0) begin
      p = poke_q.pop_front();
      mem[p.addr]     = p.data;
      ref_mem[p.addr] = p.data;
    end
    if (!rst_n) begin
      prev_done = 1'b0;
      busy_cnt  = 0;
    end else begin
      chk("rd_wr_exclusive", mem_read & mem_write, 0);
      chk("err_implies_done", err & ~done, 0);
      chk("done_single_cycle", done & prev_done, 0);
      if (busy) busy_cnt++;
      if (mem_read || mem_write) begin
        if (acc_q.size() == 0) begin
          fail("unexpected_strobe", $sformatf("rd=%0b wr=%0b addr=%0h", mem_read, mem_write, mem_addr));
        end else begin
          a = acc_q.pop_front();
          chk("acc_is_write", mem_write, a.wr);
          chk("acc_addr", mem_addr, a.addr);
          if (a.wr) begin
            chk("wr_data", mem_wdata, a.data);
            ref_mem[a.addr] = a.data;
          end
        end
      end
      if (mem_write) mem[mem_addr] = mem_wdata;
      if (done) begin
        ndone++;
        if (done_q.size() == 0) begin
          fail("unexpected_done", $sformatf("err=%0b", err));
        end else begin
          r = done_q.pop_front();
          chk("done_err", err, r.err);
          chk("done_cycle", cyc, r.cyc);
          chk("busy_cycles", busy_cnt, r.busy);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    poke_t p;
    p.addr = a; p.data = v;
    poke_q.push_back(p);
  endtask

  // Call only at a negedge while the copier is idle.
  task automatic issue(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input bit hold);
    push_expect(s, d, l, cyc + 1);
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (done_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_q.size() != 0) begin
      fail("done_timeout", $sformatf("%0d completions outstanding", done_q.size()));
      done_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("leftover_accesses", acc_q.size(), 0);
    acc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat [4];
    logic [15:0] s, d, l;
    int kind, n0, nw, diff;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Forward copy of a known pattern
    pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), pat[i]);
    repeat (2) @(negedge clk);
    issue(16'h0100, 16'h0200, 16'd4, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("fwd_word", mem[16'h0200 + 16'(i)], pat[i]);

    // Overlapping copy toward higher addresses
    pat = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), pat[i]);
    repeat (2) @(negedge clk);
    issue(16'h0100, 16'h0102, 16'd4, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("bwd_word", mem[16'h0102 + 16'(i)], pat[i]);

    // Rejected requests and an empty copy
    issue(16'h0004, 16'h0200, 16'd1, 1'b0); wait_idle();
    issue(16'h0100, 16'h7FFE, 16'd3, 1'b0); wait_idle();
    issue(16'hFFFF, 16'h0200, 16'd2, 1'b0); wait_idle();
    issue(16'h0100, 16'h0200, 16'd0, 1'b0); wait_idle();

    // start pulsed while busy is ignored
    n0 = ndone;
    issue(16'h0120, 16'h0140, 16'd3, 1'b0);
    @(negedge clk);
    start = 1'b1; src = 16'h0100; dst = 16'h0180; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_start_done_count", ndone - n0, 1);

    // start held high restarts the same copy right after completion
    n0 = ndone;
    issue(16'h0500, 16'h0600, 16'd2, 1'b1);
    push_expect(16'h0500, 16'h0600, 16'd2, cyc + 6);
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("held_start_done_count", ndone - n0, 2);

    // Randomized requests around the legal range edges and overlapping windows
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin s = 16'($urandom); d = 16'($urandom); l = 16'($urandom_range(0, 5)); end
        1: begin s = 16'h7FFF - 16'($urandom_range(0, 4)); d = 16'h0200 + 16'($urandom_range(0, 8));
                 l = 16'($urandom_range(0, 5)); end
        2: begin s = 16'($urandom_range(4, 12)); d = 16'($urandom_range(4, 12));
                 l = 16'($urandom_range(0, 4)); end
        3: begin s = 16'h0100; d = 16'h0200; l = 16'hFFF0 + 16'($urandom_range(0, 15)); end
        default: begin s = 16'h0100 + 16'($urandom_range(0, 12)); d = 16'h0100 + 16'($urandom_range(0, 12));
                       l = 16'($urandom_range(0, 6)); end
      endcase
      issue(s, d, l, 1'b0);
      wait_idle();
    end

    // Asynchronous reset during a write of a long copy
    issue(16'h0300, 16'h0400, 16'd8, 1'b0);
    nw = 0;
    for (int t = 0; t < 40 && nw < 3; t++) begin
      @(negedge clk);
      if (mem_write) nw++;
    end
    chk("reached_third_write", nw, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_mem_read", mem_read, 0);
    chk("arst_mem_write", mem_write, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    acc_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0310, 16'h0410, 16'd1, 1'b0);
    wait_idle();

    diff = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image_diffs", diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
